// File: rtl/nn3_mem_arb_pkg.sv
// Shared widths, data types and round-robin pointer encoding for the nn3
// scratch-memory arbiter.
package nn3_mem_pkg;

  localparam int AW = 13;
  localparam int DW = 32;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

  // Which of loader / writeback gets the write port on the next tie.
  typedef enum logic {
    RR_LD = 1'b0,
    RR_WB = 1'b1
  } rr_ptr_t;

  // The ce starvation counter saturates at 15, so 4 bits cover it.
  localparam int STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_MAX = 4'd15;

endpackage

// File: rtl/nn3_mem_arb_if.sv
// Requester and memory-side signals of the nn3 scratch-memory arbiter.
//
// Handshake: every requester raises req with its address/data; the arbiter
// answers with a combinational gnt in the same cycle. A request is served on
// a rising clock edge where req and gnt are both high, and adr/wdata are
// sampled at that edge. req does not have to wait for gnt, and a requester
// that is not granted may keep or drop its request.
interface nn3_mem_arb_if #(
  parameter int AW = nn3_mem_pkg::AW,
  parameter int DW = nn3_mem_pkg::DW
);
  import nn3_mem_pkg::*;

  // host config bus
  logic          host_req;
  logic          host_rw;
  logic [AW-1:0] host_adr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  // input-stream loader
  logic          ld_req;
  logic [AW-1:0] ld_adr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  // result writeback
  logic          wb_req;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_wdata;
  logic          wb_gnt;
  // compute engine dual read
  logic          ce_req;
  logic [AW-1:0] ce_adr0;
  logic [AW-1:0] ce_adr1;
  logic          ce_gnt;
  logic          ce_rvalid;
  logic [DW-1:0] ce_rdata0;
  logic [DW-1:0] ce_rdata1;
  // memory side
  logic [AW-1:0] mwadr;
  logic          mwrite;
  logic [DW-1:0] mwdata;
  logic [AW-1:0] mr0;
  logic [AW-1:0] mr1;
  logic [DW-1:0] mrdata0;
  logic [DW-1:0] mrdata1;
  // internal state made visible for checkers
  rr_ptr_t              dbg_rr_ptr;
  logic [STARVE_W-1:0]  dbg_starve;

  // arbiter side
  modport slave (
    input  host_req, host_rw, host_adr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    input  ld_req, ld_adr, ld_wdata,
    output ld_gnt,
    input  wb_req, wb_adr, wb_wdata,
    output wb_gnt,
    input  ce_req, ce_adr0, ce_adr1,
    output ce_gnt, ce_rvalid, ce_rdata0, ce_rdata1,
    output mwadr, mwrite, mwdata, mr0, mr1,
    input  mrdata0, mrdata1,
    output dbg_rr_ptr, dbg_starve
  );

  // requesters plus the memory itself
  modport master (
    output host_req, host_rw, host_adr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    output ld_req, ld_adr, ld_wdata,
    input  ld_gnt,
    output wb_req, wb_adr, wb_wdata,
    input  wb_gnt,
    output ce_req, ce_adr0, ce_adr1,
    input  ce_gnt, ce_rvalid, ce_rdata0, ce_rdata1,
    input  mwadr, mwrite, mwdata, mr0, mr1,
    output mrdata0, mrdata1,
    input  dbg_rr_ptr, dbg_starve
  );

endinterface

// File: rtl/nn3_mem_arb_rr2.sv
// Two-requester round-robin (loader vs writeback) for the memory write port.
// The pointer only moves when both sides compete and the port is free;
// a lone requester is granted without disturbing the pointer.
module nn3_rr2
  import nn3_mem_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  logic    req_ld,
  input  logic    req_wb,
  output logic    gnt_ld,
  output logic    gnt_wb,
  output rr_ptr_t ptr
);

  rr_ptr_t ptr_next;

  // pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= RR_LD;
    end else begin
      ptr <= ptr_next;
    end
  end

  // grant selection and next pointer
  always_comb begin
    gnt_ld   = 1'b0;
    gnt_wb   = 1'b0;
    ptr_next = ptr;
    if (en) begin
      if (req_ld && req_wb) begin
        gnt_ld   = (ptr == RR_LD);
        gnt_wb   = (ptr == RR_WB);
        ptr_next = (ptr == RR_LD) ? RR_WB : RR_LD;
      end else begin
        gnt_ld = req_ld;
        gnt_wb = req_wb;
      end
    end
  end

endmodule

// File: rtl/nn3_mem_arb.sv
// Arbiter/scheduler for the nn3 scratch memory: one write port shared by
// host / loader / writeback, read port 0 shared by host and the compute
// engine, read port 1 owned by the compute engine. All memory-side outputs
// are registered; read data returns two cycles after the grant.
module nn3_mem_arb
  import nn3_mem_pkg::*;
#(
  parameter int AW          = nn3_mem_pkg::AW,
  parameter int DW          = nn3_mem_pkg::DW,
  parameter int CE_MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  nn3_mem_arb_if.slave bus
);

  localparam logic [STARVE_W-1:0] CE_LIMIT = STARVE_W'(CE_MAX_WAIT);

  logic                host_wr;
  logic                host_rd;
  logic                ce_force;
  logic                ce_gnt_c;
  logic                host_gnt_c;
  logic                host_rd_go;
  logic                wr_free;
  logic                ld_gnt_c;
  logic                wb_gnt_c;
  rr_ptr_t             rr_ptr;
  logic [STARVE_W-1:0] starve;

  logic                wr_en_q;
  logic [AW-1:0]       wr_adr_q;
  logic [DW-1:0]       wr_data_q;
  logic [AW-1:0]       mr0_q;
  logic [AW-1:0]       mr1_q;
  logic                host_rd_p;
  logic                ce_rd_p;
  logic                host_rvalid_q;
  logic [DW-1:0]       host_rdata_q;
  logic                ce_rvalid_q;
  logic [DW-1:0]       ce_rdata0_q;
  logic [DW-1:0]       ce_rdata1_q;

  // Read port 0 decision: host read wins unless ce has starved long enough.
  // A host write never touches the read ports, so it coexists with ce.
  always_comb begin
    host_wr    = bus.host_req & bus.host_rw;
    host_rd    = bus.host_req & ~bus.host_rw;
    ce_force   = (starve >= CE_LIMIT);
    ce_gnt_c   = bus.ce_req & (~host_rd | ce_force);
    host_rd_go = host_rd & ~ce_gnt_c;
    host_gnt_c = host_wr | host_rd_go;
    wr_free    = ~host_wr;
  end

  // ld/wb share whatever the host write leaves free
  nn3_rr2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .en     (wr_free),
    .req_ld (bus.ld_req),
    .req_wb (bus.wb_req),
    .gnt_ld (ld_gnt_c),
    .gnt_wb (wb_gnt_c),
    .ptr    (rr_ptr)
  );

  // ce starvation counter: counts denied ce cycles, clears when ce is served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (ce_gnt_c) begin
      starve <= '0;
    end else if (bus.ce_req && (starve != STARVE_MAX)) begin
      starve <= starve + 4'd1;
    end
  end

  // write stage: one-cycle mwrite pulse per grant, address/data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= host_wr | ld_gnt_c | wb_gnt_c;
      if (host_wr) begin
        wr_adr_q  <= bus.host_adr;
        wr_data_q <= bus.host_wdata;
      end else if (ld_gnt_c) begin
        wr_adr_q  <= bus.ld_adr;
        wr_data_q <= bus.ld_wdata;
      end else if (wb_gnt_c) begin
        wr_adr_q  <= bus.wb_adr;
        wr_data_q <= bus.wb_wdata;
      end
    end
  end

  // read address stage: mr1 only moves for ce, both hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mr0_q     <= '0;
      mr1_q     <= '0;
      host_rd_p <= 1'b0;
      ce_rd_p   <= 1'b0;
    end else begin
      host_rd_p <= host_rd_go;
      ce_rd_p   <= ce_gnt_c;
      if (ce_gnt_c) begin
        mr0_q <= bus.ce_adr0;
        mr1_q <= bus.ce_adr1;
      end else if (host_rd_go) begin
        mr0_q <= bus.host_adr;
      end
    end
  end

  // read data stage: capture asynchronous memory data, raise rvalid one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      ce_rvalid_q   <= 1'b0;
      ce_rdata0_q   <= '0;
      ce_rdata1_q   <= '0;
    end else begin
      host_rvalid_q <= host_rd_p;
      ce_rvalid_q   <= ce_rd_p;
      if (host_rd_p) begin
        host_rdata_q <= bus.mrdata0;
      end
      if (ce_rd_p) begin
        ce_rdata0_q <= bus.mrdata0;
        ce_rdata1_q <= bus.mrdata1;
      end
    end
  end

  assign bus.host_gnt    = host_gnt_c;
  assign bus.ld_gnt      = ld_gnt_c;
  assign bus.wb_gnt      = wb_gnt_c;
  assign bus.ce_gnt      = ce_gnt_c;
  assign bus.mwrite      = wr_en_q;
  assign bus.mwadr       = wr_adr_q;
  assign bus.mwdata      = wr_data_q;
  assign bus.mr0         = mr0_q;
  assign bus.mr1         = mr1_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.ce_rvalid   = ce_rvalid_q;
  assign bus.ce_rdata0   = ce_rdata0_q;
  assign bus.ce_rdata1   = ce_rdata1_q;
  assign bus.dbg_rr_ptr  = rr_ptr;
  assign bus.dbg_starve  = starve;

endmodule

// File: tb/tb_nn3_mem_arb.sv
// Bench for nn3_mem_arb: directed scenarios plus a randomized run against a
// transaction-level reference model (grant rules + golden memory image).
module tb_nn3_mem_arb;

  localparam int AW          = 13;
  localparam int DW          = 32;
  localparam int CE_MAX_WAIT = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  nn3_mem_arb_if #(.AW(AW), .DW(DW)) bus ();

  nn3_mem_arb #(.AW(AW), .DW(DW), .CE_MAX_WAIT(CE_MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scratch memory: synchronous write, asynchronous reads, backdoor preload
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_clr  = 1'b1;
  logic          pre_en   = 1'b0;
  logic [AW-1:0] pre_adr  = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else begin
      if (bus.mwrite) mem[bus.mwadr] <= bus.mwdata;
      if (pre_en) mem[pre_adr] <= pre_data;
    end
  end
  assign bus.mrdata0 = mem[bus.mr0];
  assign bus.mrdata1 = mem[bus.mr1];

  // driver tasks
  task automatic clear_inputs();
    bus.host_req = 1'b0; bus.host_rw = 1'b0; bus.host_adr = '0; bus.host_wdata = '0;
    bus.ld_req = 1'b0; bus.ld_adr = '0; bus.ld_wdata = '0;
    bus.wb_req = 1'b0; bus.wb_adr = '0; bus.wb_wdata = '0;
    bus.ce_req = 1'b0; bus.ce_adr0 = '0; bus.ce_adr1 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.host_gnt !== 1'b0 || bus.ld_gnt !== 1'b0 || bus.wb_gnt !== 1'b0 || bus.ce_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnts: got %b%b%b%b want 0000", bus.host_gnt, bus.ld_gnt, bus.wb_gnt, bus.ce_gnt); end
    checks++; if (bus.mwrite !== 1'b0) begin errors++; $display("FAIL rst_mwrite: got %b want 0", bus.mwrite); end
    checks++; if (bus.mwadr !== '0 || bus.mwdata !== '0) begin errors++; $display("FAIL rst_wregs: got %h/%h want 0/0", bus.mwadr, bus.mwdata); end
    checks++; if (bus.mr0 !== '0 || bus.mr1 !== '0) begin errors++; $display("FAIL rst_mr: got %h/%h want 0/0", bus.mr0, bus.mr1); end
    checks++; if (bus.host_rvalid !== 1'b0 || bus.ce_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b/%b want 0/0", bus.host_rvalid, bus.ce_rvalid); end
    checks++; if (bus.host_rdata !== '0 || bus.ce_rdata0 !== '0 || bus.ce_rdata1 !== '0) begin errors++; $display("FAIL rst_rdata: got %h/%h/%h want 0", bus.host_rdata, bus.ce_rdata0, bus.ce_rdata1); end
    checks++; if (bus.dbg_rr_ptr !== nn3_mem_pkg::RR_LD || bus.dbg_starve !== 4'd0) begin errors++; $display("FAIL rst_state: got ptr %b starve %0d want 0/0", bus.dbg_rr_ptr, bus.dbg_starve); end
    step();
  endtask

  task automatic test_host_write();
    bus.host_req = 1'b1; bus.host_rw = 1'b1; bus.host_adr = 13'h0010; bus.host_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (bus.host_gnt !== 1'b1) begin errors++; $display("FAIL hw_gnt: got %b want 1", bus.host_gnt); end
    step();
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.mwrite !== 1'b1) begin errors++; $display("FAIL hw_mwrite: got %b want 1", bus.mwrite); end
    checks++; if (bus.mwadr !== 13'h0010 || bus.mwdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hw_wregs: got %h/%h want 0010/deadbeef", bus.mwadr, bus.mwdata); end
    step();
    @(negedge clk);
    checks++; if (bus.mwrite !== 1'b0) begin errors++; $display("FAIL hw_pulse: got %b want 0", bus.mwrite); end
    checks++; if (bus.mwadr !== 13'h0010) begin errors++; $display("FAIL hw_hold: got %h want 0010", bus.mwadr); end
    checks++; if (mem[13'h0010] !== 32'hDEADBEEF) begin errors++; $display("FAIL hw_mem: got %h want deadbeef", mem[13'h0010]); end
    step();
  endtask

  task automatic test_rr_pair();
    logic [AW-1:0] p_adr;
    logic [DW-1:0] p_data;
    p_adr = '0; p_data = '0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.ld_req = 1'b1; bus.ld_adr = 13'h0020 + 13'(i); bus.ld_wdata = 32'hA000_0000 + 32'(i);
      bus.wb_req = 1'b1; bus.wb_adr = 13'h0030 + 13'(i); bus.wb_wdata = 32'hB000_0000 + 32'(i);
      @(negedge clk);
      checks++; if (bus.ld_gnt !== ((i % 2) == 0) || bus.wb_gnt !== ((i % 2) == 1)) begin errors++; $display("FAIL rr_order%0d: got ld%b wb%b want ld%b", i, bus.ld_gnt, bus.wb_gnt, (i % 2) == 0); end
      if (i > 0) begin
        checks++; if (bus.mwrite !== 1'b1 || bus.mwadr !== p_adr || bus.mwdata !== p_data) begin errors++; $display("FAIL rr_write%0d: got %b %h/%h want 1 %h/%h", i, bus.mwrite, bus.mwadr, bus.mwdata, p_adr, p_data); end
      end
      p_adr  = ((i % 2) == 0) ? bus.ld_adr : bus.wb_adr;
      p_data = ((i % 2) == 0) ? bus.ld_wdata : bus.wb_wdata;
      step();
    end
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.mwrite !== 1'b1 || bus.mwadr !== 13'h0033 || bus.mwdata !== 32'hB000_0003) begin errors++; $display("FAIL rr_last: got %b %h/%h want 1 0033/b0000003", bus.mwrite, bus.mwadr, bus.mwdata); end
    step();
    @(negedge clk);
    checks++; if (bus.mwrite !== 1'b0) begin errors++; $display("FAIL rr_end: got %b want 0", bus.mwrite); end
    step();
  endtask

  task automatic test_host_priority();
    do_reset();
    bus.host_req = 1'b1; bus.host_rw = 1'b1; bus.host_adr = 13'h0060; bus.host_wdata = 32'h0000_600D;
    bus.ld_req = 1'b1; bus.ld_adr = 13'h0061; bus.ld_wdata = 32'h61;
    bus.wb_req = 1'b1; bus.wb_adr = 13'h0062; bus.wb_wdata = 32'h62;
    @(negedge clk);
    checks++; if (bus.host_gnt !== 1'b1 || bus.ld_gnt !== 1'b0 || bus.wb_gnt !== 1'b0) begin errors++; $display("FAIL prio_host: got h%b l%b w%b want 100", bus.host_gnt, bus.ld_gnt, bus.wb_gnt); end
    step();
    bus.host_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.ld_gnt !== 1'b1 || bus.wb_gnt !== 1'b0) begin errors++; $display("FAIL prio_ptr_kept: got l%b w%b want 10", bus.ld_gnt, bus.wb_gnt); end
    checks++; if (bus.mwrite !== 1'b1 || bus.mwadr !== 13'h0060) begin errors++; $display("FAIL prio_hwrite: got %b %h want 1 0060", bus.mwrite, bus.mwadr); end
    step();
    @(negedge clk);
    checks++; if (bus.ld_gnt !== 1'b0 || bus.wb_gnt !== 1'b1) begin errors++; $display("FAIL prio_flip: got l%b w%b want 01", bus.ld_gnt, bus.wb_gnt); end
    step();
    clear_inputs();
  endtask

  task automatic test_starve();
    bit exp_ce;
    do_reset();
    bus.host_req = 1'b1; bus.host_rw = 1'b0; bus.host_adr = 13'h0040;
    bus.ce_req = 1'b1; bus.ce_adr0 = 13'h0041; bus.ce_adr1 = 13'h0042;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_ce = (c == 5);
      checks++; if (bus.host_gnt !== !exp_ce || bus.ce_gnt !== exp_ce) begin errors++; $display("FAIL starve_gnt%0d: got h%b c%b want c%b", c, bus.host_gnt, bus.ce_gnt, exp_ce); end
      checks++; if (bus.dbg_starve !== ((c == 6) ? 4'd0 : 4'(c - 1))) begin errors++; $display("FAIL starve_cnt%0d: got %0d", c, bus.dbg_starve); end
      step();
    end
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.mr0 !== 13'h0040 || bus.mr1 !== 13'h0042) begin errors++; $display("FAIL starve_mr: got %h/%h want 0040/0042", bus.mr0, bus.mr1); end
    checks++; if (bus.ce_rvalid !== 1'b1 || bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL starve_rvalid: got c%b h%b want c1 h0", bus.ce_rvalid, bus.host_rvalid); end
    step();
  endtask

  task automatic test_ce_read();
    pre_en = 1'b1; pre_adr = 13'h0100; pre_data = 32'h1111_1111;
    step();
    pre_adr = 13'h0101; pre_data = 32'h2222_2222;
    step();
    pre_en = 1'b0;
    bus.ce_req = 1'b1; bus.ce_adr0 = 13'h0100; bus.ce_adr1 = 13'h0101;
    @(negedge clk);
    checks++; if (bus.ce_gnt !== 1'b1) begin errors++; $display("FAIL ce_gnt: got %b want 1", bus.ce_gnt); end
    step();
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.ce_rvalid !== 1'b0 || bus.mr0 !== 13'h0100 || bus.mr1 !== 13'h0101) begin errors++; $display("FAIL ce_stage1: got v%b %h/%h want v0 0100/0101", bus.ce_rvalid, bus.mr0, bus.mr1); end
    step();
    @(negedge clk);
    checks++; if (bus.ce_rvalid !== 1'b1) begin errors++; $display("FAIL ce_rvalid: got %b want 1", bus.ce_rvalid); end
    checks++; if (bus.ce_rdata0 !== 32'h1111_1111 || bus.ce_rdata1 !== 32'h2222_2222) begin errors++; $display("FAIL ce_rdata: got %h/%h want 11111111/22222222", bus.ce_rdata0, bus.ce_rdata1); end
    step();
    @(negedge clk);
    checks++; if (bus.ce_rvalid !== 1'b0) begin errors++; $display("FAIL ce_rvalid_pulse: got %b want 0", bus.ce_rvalid); end
    step();
  endtask

  task automatic test_reset_mid();
    bus.host_req = 1'b1; bus.host_rw = 1'b1; bus.host_adr = 13'h0050; bus.host_wdata = 32'h1234_5678;
    bus.ce_req = 1'b1; bus.ce_adr0 = 13'h0100; bus.ce_adr1 = 13'h0101;
    @(negedge clk);
    checks++; if (bus.host_gnt !== 1'b1 || bus.ce_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnts: got h%b c%b want 11", bus.host_gnt, bus.ce_gnt); end
    step();
    clear_inputs();
    #1;
    checks++; if (bus.mwrite !== 1'b1) begin errors++; $display("FAIL mid_mwrite: got %b want 1", bus.mwrite); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.mwrite !== 1'b0 || bus.mwadr !== '0) begin errors++; $display("FAIL mid_kill: got %b %h want 0 0000", bus.mwrite, bus.mwadr); end
    step();
    rst = 1'b0;
    checks++; if (mem[13'h0050] !== 32'h0) begin errors++; $display("FAIL mid_mem: got %h want 0", mem[13'h0050]); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.ce_rvalid !== 1'b0 || bus.mwrite !== 1'b0) begin errors++; $display("FAIL mid_quiet%0d: got v%b w%b want 00", c, bus.ce_rvalid, bus.mwrite); end
      step();
    end
  endtask

  task automatic test_hazard();
    bus.ld_req = 1'b1; bus.ld_adr = 13'h0200; bus.ld_wdata = 32'h55;
    @(negedge clk);
    checks++; if (bus.ld_gnt !== 1'b1) begin errors++; $display("FAIL hz_ld_gnt: got %b want 1", bus.ld_gnt); end
    step();
    bus.ld_req = 1'b0;
    bus.ce_req = 1'b1; bus.ce_adr0 = 13'h0200; bus.ce_adr1 = 13'h0201;
    @(negedge clk);
    checks++; if (bus.ce_gnt !== 1'b1) begin errors++; $display("FAIL hz_ce_gnt: got %b want 1", bus.ce_gnt); end
    step();
    clear_inputs();
    step();
    @(negedge clk);
    checks++; if (bus.ce_rvalid !== 1'b1 || bus.ce_rdata0 !== 32'h55) begin errors++; $display("FAIL hz_new: got v%b %h want v1 00000055", bus.ce_rvalid, bus.ce_rdata0); end
    step();
    // write and read of the same address granted together: read sees old data
    bus.host_req = 1'b1; bus.host_rw = 1'b1; bus.host_adr = 13'h0300; bus.host_wdata = 32'hAA;
    bus.ce_req = 1'b1; bus.ce_adr0 = 13'h0300; bus.ce_adr1 = 13'h0200;
    @(negedge clk);
    checks++; if (bus.host_gnt !== 1'b1 || bus.ce_gnt !== 1'b1) begin errors++; $display("FAIL hz_both: got h%b c%b want 11", bus.host_gnt, bus.ce_gnt); end
    step();
    clear_inputs();
    step();
    @(negedge clk);
    checks++; if (bus.ce_rvalid !== 1'b1 || bus.ce_rdata0 !== 32'h0 || bus.ce_rdata1 !== 32'h55) begin errors++; $display("FAIL hz_old: got v%b %h/%h want v1 0/55", bus.ce_rvalid, bus.ce_rdata0, bus.ce_rdata1); end
    checks++; if (mem[13'h0300] !== 32'hAA) begin errors++; $display("FAIL hz_mem: got %h want aa", mem[13'h0300]); end
    step();
  endtask

  // Randomized traffic. Model: fixed priority rules on the current requests,
  // a golden memory image where every read sees exactly the writes granted
  // at earlier edges, and expected read results queued with their due cycle.
  task automatic test_random();
    logic [DW-1:0]   ref_mem [0:7];
    logic [DW-1:0]   exp_q[$];
    int              exp_due_q[$];
    logic [2*DW-1:0] exp_ce_q[$];
    int              exp_ce_due_q[$];
    bit              ld_turn;
    int              m_starve;
    bit              w_pend;
    logic [AW-1:0]   w_adr, last_wadr, last_mr0, last_mr1;
    logic [DW-1:0]   w_data, last_wdata;
    bit              hw, hr, e_host, e_ld, e_wb, e_ce, e_hv, e_cv;
    do_reset();
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    ld_turn = 1'b1; m_starve = 0; w_pend = 1'b0;
    w_adr = '0; w_data = '0; last_wadr = '0; last_wdata = '0; last_mr0 = '0; last_mr1 = '0;
    for (int c = 0; c < 400; c++) begin
      bus.host_req = ($urandom_range(0, 3) != 0); bus.host_rw = 1'($urandom_range(0, 1));
      bus.host_adr = 13'h1000 + 13'($urandom_range(0, 7)); bus.host_wdata = $urandom;
      bus.ld_req = 1'($urandom_range(0, 1)); bus.ld_adr = 13'h1000 + 13'($urandom_range(0, 7)); bus.ld_wdata = $urandom;
      bus.wb_req = 1'($urandom_range(0, 1)); bus.wb_adr = 13'h1000 + 13'($urandom_range(0, 7)); bus.wb_wdata = $urandom;
      bus.ce_req = 1'($urandom_range(0, 1));
      bus.ce_adr0 = 13'h1000 + 13'($urandom_range(0, 7)); bus.ce_adr1 = 13'h1000 + 13'($urandom_range(0, 7));
      @(negedge clk);
      hw     = bus.host_req && bus.host_rw;
      hr     = bus.host_req && !bus.host_rw;
      e_ce   = bus.ce_req && (!hr || m_starve >= CE_MAX_WAIT);
      e_host = hw || (hr && !e_ce);
      e_ld   = !hw && bus.ld_req && (!bus.wb_req || ld_turn);
      e_wb   = !hw && bus.wb_req && (!bus.ld_req || !ld_turn);
      e_hv   = (exp_due_q.size() != 0) && (exp_due_q[0] == c);
      e_cv   = (exp_ce_due_q.size() != 0) && (exp_ce_due_q[0] == c);
      checks++; if (bus.host_gnt !== e_host || bus.ce_gnt !== e_ce) begin errors++; $display("FAIL rnd_rgnt c%0d: got h%b c%b want h%b c%b", c, bus.host_gnt, bus.ce_gnt, e_host, e_ce); end
      checks++; if (bus.ld_gnt !== e_ld || bus.wb_gnt !== e_wb) begin errors++; $display("FAIL rnd_wgnt c%0d: got l%b w%b want l%b w%b", c, bus.ld_gnt, bus.wb_gnt, e_ld, e_wb); end
      checks++; if (bus.mwrite !== w_pend || bus.mwadr !== last_wadr || bus.mwdata !== last_wdata) begin errors++; $display("FAIL rnd_wport c%0d: got %b %h/%h want %b %h/%h", c, bus.mwrite, bus.mwadr, bus.mwdata, w_pend, last_wadr, last_wdata); end
      checks++; if (bus.mr0 !== last_mr0 || bus.mr1 !== last_mr1) begin errors++; $display("FAIL rnd_mr c%0d: got %h/%h want %h/%h", c, bus.mr0, bus.mr1, last_mr0, last_mr1); end
      checks++; if (bus.dbg_starve !== 4'(m_starve)) begin errors++; $display("FAIL rnd_starve c%0d: got %0d want %0d", c, bus.dbg_starve, m_starve); end
      checks++; if (bus.host_rvalid !== e_hv || bus.ce_rvalid !== e_cv) begin errors++; $display("FAIL rnd_rvalid c%0d: got h%b c%b want h%b c%b", c, bus.host_rvalid, bus.ce_rvalid, e_hv, e_cv); end
      if (e_hv) begin
        checks++; if (bus.host_rdata !== exp_q[0]) begin errors++; $display("FAIL rnd_hdata c%0d: got %h want %h", c, bus.host_rdata, exp_q[0]); end
        void'(exp_q.pop_front()); void'(exp_due_q.pop_front());
      end
      if (e_cv) begin
        checks++; if ({bus.ce_rdata1, bus.ce_rdata0} !== exp_ce_q[0]) begin errors++; $display("FAIL rnd_cdata c%0d: got %h want %h", c, {bus.ce_rdata1, bus.ce_rdata0}, exp_ce_q[0]); end
        void'(exp_ce_q.pop_front()); void'(exp_ce_due_q.pop_front());
      end
      @(posedge clk);
      if (hr && e_host) begin
        exp_q.push_back(ref_mem[bus.host_adr[2:0]]); exp_due_q.push_back(c + 2);
        last_mr0 = bus.host_adr;
      end
      if (e_ce) begin
        exp_ce_q.push_back({ref_mem[bus.ce_adr1[2:0]], ref_mem[bus.ce_adr0[2:0]]}); exp_ce_due_q.push_back(c + 2);
        last_mr0 = bus.ce_adr0; last_mr1 = bus.ce_adr1;
      end
      w_pend = hw || e_ld || e_wb;
      if (hw) begin w_adr = bus.host_adr; w_data = bus.host_wdata; end
      else if (e_ld) begin w_adr = bus.ld_adr; w_data = bus.ld_wdata; end
      else if (e_wb) begin w_adr = bus.wb_adr; w_data = bus.wb_wdata; end
      if (w_pend) begin
        last_wadr = w_adr; last_wdata = w_data; ref_mem[w_adr[2:0]] = w_data;
      end
      if (!hw && bus.ld_req && bus.wb_req) ld_turn = !ld_turn;
      if (e_ce) m_starve = 0;
      else if (bus.ce_req && m_starve < 15) m_starve++;
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    step();
    mem_clr = 1'b0;
    step();
    rst = 1'b0;
    test_reset();
    test_host_write();
    test_rr_pair();
    test_host_priority();
    test_starve();
    test_ce_read();
    test_reset_mid();
    test_hazard();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
